// File: rtl/hazard_scoreboard.sv
// Register-dependency scoreboard and decode stall controller for the in-order RV32 pipeline.
// Optional writeback bypass of source hazards: define HAZARD_WB_BYPASS_EN.
module hazard_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic [4:0]  rs1_ind,
  input  logic [4:0]  rs2_ind,
  input  logic        rs1_used,
  input  logic        rs2_used,
  input  logic [4:0]  rd_ind,
  input  logic        rd_wr,
  input  logic        stall_in,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd_ind,
  input  logic        flush,
  output logic        stall_out,
  output logic        issue,
  output logic [31:0] sb_pending,
  output logic        sb_err
);

  localparam int unsigned NREG = 32;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             sb_err_q;
  logic             sb_err_d;

  logic raw1;
  logic raw2;
  logic sat;
  logic inc;
  logic dec;
  logic byp1;
  logic byp2;

  // Writeback bypass: last pending writer retiring this cycle supplies the operand
`ifdef HAZARD_WB_BYPASS_EN
  assign byp1 = wb_valid && (wb_rd_ind == rs1_ind) && (cnt_q[rs1_ind] == CNT_ONE);
  assign byp2 = wb_valid && (wb_rd_ind == rs2_ind) && (cnt_q[rs2_ind] == CNT_ONE);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign raw1 = rs1_used && (rs1_ind != 5'd0) && (cnt_q[rs1_ind] != CNT_ZERO) && !byp1;
  assign raw2 = rs2_used && (rs2_ind != 5'd0) && (cnt_q[rs2_ind] != CNT_ZERO) && !byp2;
  assign sat  = rd_wr && (rd_ind != 5'd0) && (cnt_q[rd_ind] == CNT_MAX);

  assign stall_out = dec_valid && !flush && (raw1 || raw2 || sat);
  assign issue     = dec_valid && !flush && !stall_out && !stall_in;

  assign inc = issue && rd_wr && (rd_ind != 5'd0);
  assign dec = wb_valid && (wb_rd_ind != 5'd0);

  // Counter next state: flush clears, same-index inc/dec cancels, underflow flags error
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    sb_err_d = sb_err_q;
    if (flush) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_d[i] = CNT_ZERO;
      end
    end else if (!(inc && dec && (rd_ind == wb_rd_ind))) begin
      if (inc) begin
        cnt_d[rd_ind] = cnt_q[rd_ind] + CNT_ONE;
      end
      if (dec) begin
        if (cnt_q[wb_rd_ind] == CNT_ZERO) begin
          sb_err_d = 1'b1;
        end else begin
          cnt_d[wb_rd_ind] = cnt_q[wb_rd_ind] - CNT_ONE;
        end
      end
    end
    cnt_d[0] = CNT_ZERO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
      sb_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sb_err_q <= sb_err_d;
    end
  end

  always_comb begin
    sb_pending = '0;
    for (int i = 1; i < NREG; i++) begin
      sb_pending[i] = (cnt_q[i] != CNT_ZERO);
    end
  end

  assign sb_err = sb_err_q;

endmodule
